stream_mux_rr: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshake on every input and on the output.
- Successor to the 4:1 combinational muxes: adds a registered output stage, backpressure, and two selection modes (external select, round-robin).
- Sits between multiple producer channels and a single consumer, e.g. funnelling several datapaths into one shared unit.

---
 rtl/stream_mux_rr.sv | 145 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready stream mux with select and round-robin modes, registered output
// Optional packet lock (in_last/out_last) enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             free, xfer, gnt_vld;
  logic [SEL_W-1:0] gnt_idx;

  // Channel index base+off with wrap at CHANNELS; base is always < CHANNELS.
  function automatic logic [SEL_W-1:0] rr_pos(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

`ifdef STREAM_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode) begin
      // Walk offsets from far to near so the nearest valid channel after rr_ptr wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        if (in_valid[rr_pos(rr_ptr_q, k)]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_pos(rr_ptr_q, k);
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    if (lock_q) begin
      gnt_vld = in_valid[lock_ch_q];
      gnt_idx = lock_ch_q;
    end
`endif
  end

  assign free = !out_valid_q || out_ready;
  assign xfer = gnt_vld && free;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[gnt_idx];
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (mode) rr_ptr_d = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (xfer) begin
      lock_d     = !in_last[gnt_idx];
      lock_ch_d  = gnt_idx;
      out_last_d = in_last[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed self-checking bench for stream_mux_rr (lock test under STREAM_MUX_LOCK_EN)
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic        mode5 = 1'b0;
  logic [2:0]  sel5 = '0;
  logic [39:0] in_data5 = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};
  logic [4:0]  in_valid5 = '0;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5;
  logic        out_ready5 = 1'b1;

`ifdef STREAM_MUX_LOCK_EN
  logic [3:0]  in_last = '0;
  logic        out_last;
  logic [4:0]  in_last5 = '1;
  logic        out_last5;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last5), .out_last(out_last5),
`endif
    .out_data(out_data5), .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d exp 0", out_ch); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", in_ready); end
    checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL reset_valid5: got %b exp 0", out_valid5); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_select();
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid = 4'b0110;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel_ready: got %b exp 0100", in_ready); end
    step();
    in_valid = 4'b0000;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel_valid: got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL sel_data: got %h exp a5", out_data); end
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL sel_ch: got %0d exp 2", out_ch); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL sel_hold_data: got %h exp a5", out_data); end
  endtask

  task automatic test_select_bounds();
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL sel3_ready: got %b exp 0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel3_valid: got %b exp 0", out_valid); end
    in_valid = 4'b0000;
    mode5 = 1'b0; sel5 = 3'd4; in_valid5 = 5'b11111;
    #1;
    checks++; if (in_ready5 !== 5'b10000) begin errors++; $display("FAIL sel4_ready5: got %b exp 10000", in_ready5); end
    step();
    checks++; if (out_ch5 !== 3'd4 || out_data5 !== 8'hE4) begin errors++; $display("FAIL sel4_out5: got ch %0d data %h exp ch 4 data e4", out_ch5, out_data5); end
    sel5 = 3'd5;
    #1;
    checks++; if (in_ready5 !== 5'b00000) begin errors++; $display("FAIL sel5_ready5: got %b exp 00000", in_ready5); end
    step();
    checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL sel5_valid5: got %b exp 0", out_valid5); end
    sel5 = 3'd7;
    #1;
    checks++; if (in_ready5 !== 5'b00000) begin errors++; $display("FAIL sel7_ready5: got %b exp 00000", in_ready5); end
    in_valid5 = '0;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'hA0; exp_data[1] = 8'hB1; exp_data[2] = 8'hC2; exp_data[3] = 8'hD3;
    in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      #1;
      checks++; if (in_ready !== (4'b0001 << (n % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %b exp ch %0d", n, in_ready, n % 4); end
      step();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'(n % 4) || out_data !== exp_data[n % 4]) begin
        errors++; $display("FAIL rr_out[%0d]: got v %b ch %0d data %h exp v 1 ch %0d data %h", n, out_valid, out_ch, out_data, n % 4, exp_data[n % 4]);
      end
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 0000", n, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'hD3) begin
        errors++; $display("FAIL bp_hold[%0d]: got v %b ch %0d data %h exp v 1 ch 3 data d3", n, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b exp 0001", in_ready); end
    step();
    checks++; if (out_ch !== 2'd0 || out_data !== 8'hA0) begin errors++; $display("FAIL bp_next0: got ch %0d data %h exp ch 0 data a0", out_ch, out_data); end
    step();
    checks++; if (out_ch !== 2'd1 || out_data !== 8'hB1) begin errors++; $display("FAIL bp_next1: got ch %0d data %h exp ch 1 data b1", out_ch, out_data); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_ch [4];
    exp_ch[0] = 2'd3; exp_ch[1] = 2'd1; exp_ch[2] = 2'd3; exp_ch[3] = 2'd1;
    in_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch[n]) begin
        errors++; $display("FAIL wrap[%0d]: got v %b ch %0d exp v 1 ch %0d", n, out_valid, out_ch, exp_ch[n]);
      end
    end
    in_valid = 4'b0000;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b exp 0", out_valid); end
  endtask

`ifdef STREAM_MUX_LOCK_EN
  task automatic test_lock();
    mode = 1'b1; out_ready = 1'b1; in_last = 4'b0000; in_valid = 4'b0011;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_first_ready: got %b exp 0001", in_ready); end
    step();
    checks++; if (out_ch !== 2'd0 || out_last !== 1'b0) begin errors++; $display("FAIL lock_w0: got ch %0d last %b exp ch 0 last 0", out_ch, out_last); end
    in_valid = 4'b0010;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL lock_block: got %b exp 0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_gap_valid: got %b exp 0", out_valid); end
    in_valid = 4'b0011;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_hold_ready: got %b exp 0001", in_ready); end
    step();
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL lock_w1: got ch %0d exp 0", out_ch); end
    in_last = 4'b0001;
    step();
    checks++; if (out_ch !== 2'd0 || out_last !== 1'b1) begin errors++; $display("FAIL lock_w2: got ch %0d last %b exp ch 0 last 1", out_ch, out_last); end
    in_last = 4'b0011;
    step();
    checks++; if (out_ch !== 2'd1) begin errors++; $display("FAIL lock_after: got ch %0d exp 1", out_ch); end
    in_last = 4'b0000; in_valid = 4'b0001;
    step();
    checks++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL lock_repkt: got ch %0d v %b exp ch 0 v 1", out_ch, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL lock_rst_async: got v %b last %b exp 0 0", out_valid, out_last); end
    step();
    rst_n = 1'b1;
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0011;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_cleared: got %b exp 0010", in_ready); end
    step();
    checks++; if (out_ch !== 2'd1) begin errors++; $display("FAIL lock_cleared_ch: got %0d exp 1", out_ch); end
    in_valid = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_select();
    test_select_bounds();
    test_round_robin();
    test_back_pressure();
    test_wrap();
`ifdef STREAM_MUX_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
